// File: rtl/adrv9001_rx_ssi_unpack.sv
// ADRV9001/2 receive SSI deframer. It locks to the one-in-16 strobe and
// recovers the bit offset. It rebuilds 16-bit I/Q samples into 32-bit stream
// words and can check the recovered data against a ramp or a fixed pattern.
module adrv9001_rx_ssi_unpack #(
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic        serdes_clk_div,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  s_din,
    input  logic [7:0]  i_din,
    input  logic [7:0]  q_din,
    input  logic        swap_iq,
    input  logic [1:0]  check_mode,
    input  logic [31:0] fixed_pattern,
    input  logic        check_err_clr,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        locked,
    output logic [2:0]  strobe_offset,
    output logic [15:0] strobe_err_cnt,
    output logic [15:0] check_err_cnt
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_FIXED = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Position of the set bit counted from the MSB (earliest bit on the wire).
    function automatic logic [2:0] bit_offset(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[7-k]) idx = 3'(k);
        end
        return idx;
    endfunction

    // 16 bits starting b bits into the oldest of three consecutive words.
    function automatic logic [15:0] unpack16(input logic [7:0] w2, input logic [7:0] w1,
                                             input logic [7:0] w0, input logic [2:0] b);
        logic [23:0] w;
        w = {w2, w1, w0} << b;
        return w[23:8];
    endfunction

    logic [7:0]  s_p0_q, s_p1_q, s_p2_q, i_p0_q, i_p1_q, i_p2_q, q_p0_q, q_p1_q, q_p2_q;
    logic [7:0]  s_p0_d, s_p1_d, s_p2_d, i_p0_d, i_p1_d, i_p2_d, q_p0_d, q_p1_d, q_p2_d;
    logic [1:0]  state_q, state_d;
    logic        phase_q, phase_d;
    logic [2:0]  offset_q, offset_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [7:0]  bad_run_q, bad_run_d;
    logic        zero_ok_q, zero_ok_d;
    logic [15:0] strobe_err_q, strobe_err_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic [15:0] check_err_q, check_err_d;
    logic [31:0] ref_q, ref_d;
    logic        seeded_q, seeded_d;
    logic [1:0]  mode_q, mode_d;

    logic        cand, strobe_ok, zero_ok, word_err, mode_chg;
    logic [15:0] i_word, q_word;

    // Three-deep word history per lane: r0 newest, r2 oldest.
    always_comb begin
        s_p0_d = s_din;  s_p1_d = s_p0_q;  s_p2_d = s_p1_q;
        i_p0_d = i_din;  i_p1_d = i_p0_q;  i_p2_d = i_p1_q;
        q_p0_d = q_din;  q_p1_d = q_p0_q;  q_p2_d = q_p1_q;
    end

    // Pure data pipeline, deliberately left without reset.
    always_ff @(posedge serdes_clk_div) begin
        s_p0_q <= s_p0_d;  s_p1_q <= s_p1_d;  s_p2_q <= s_p2_d;
        i_p0_q <= i_p0_d;  i_p1_q <= i_p1_d;  i_p2_q <= i_p2_d;
        q_p0_q <= q_p0_d;  q_p1_q <= q_p1_d;  q_p2_q <= q_p2_d;
    end

    // Strobe search / verify / lock state machine with period bookkeeping.
    always_comb begin
        cand      = (s_p0_q != 8'd0) && ((s_p0_q & (s_p0_q - 8'd1)) == 8'd0) && (s_p1_q == 8'd0);
        strobe_ok = (s_p0_q == (8'h80 >> offset_q));
        zero_ok   = (s_p0_q == 8'd0);
        state_d      = state_q;
        phase_d      = ~phase_q;
        offset_d     = offset_q;
        match_cnt_d  = match_cnt_q;
        bad_run_d    = bad_run_q;
        zero_ok_d    = zero_ok_q;
        strobe_err_d = strobe_err_q;
        case (state_q)
            ST_VERIFY: begin
                if (phase_q) begin
                    if (!zero_ok) begin
                        state_d     = ST_SEARCH;
                        match_cnt_d = 8'd0;
                    end
                end else if (!strobe_ok) begin
                    state_d     = ST_SEARCH;
                    match_cnt_d = 8'd0;
                end else if (match_cnt_q == 8'(LOCK_COUNT - 1)) begin
                    state_d      = ST_LOCKED;
                    match_cnt_d  = 8'd0;
                    bad_run_d    = 8'd0;
                    strobe_err_d = 16'd0;
                end else begin
                    match_cnt_d = match_cnt_q + 8'd1;
                end
            end
            ST_LOCKED: begin
                if (phase_q) begin
                    zero_ok_d = zero_ok;
                end else if (zero_ok_q && strobe_ok) begin
                    bad_run_d = 8'd0;
                end else begin
                    strobe_err_d = sat_inc16(strobe_err_q);
                    if (bad_run_q == 8'(UNLOCK_COUNT - 1)) begin
                        state_d   = ST_SEARCH;
                        bad_run_d = 8'd0;
                    end else begin
                        bad_run_d = bad_run_q + 8'd1;
                    end
                end
            end
            default: begin
                phase_d = 1'b0;
                if (cand) begin
                    state_d     = ST_VERIFY;
                    offset_d    = bit_offset(s_p0_q);
                    phase_d     = 1'b1;
                    match_cnt_d = 8'd0;
                end
            end
        endcase
        if (!enable) begin
            state_d     = ST_SEARCH;
            phase_d     = 1'b0;
            match_cnt_d = 8'd0;
            bad_run_d   = 8'd0;
        end
    end

    // Sample reassembly: strobe word sits in r2 on locked phase-0 cycles.
    always_comb begin
        i_word   = unpack16(i_p2_q, i_p1_q, i_p0_q, offset_q);
        q_word   = unpack16(q_p2_q, q_p1_q, q_p0_q, offset_q);
        tvalid_d = enable && (state_q == ST_LOCKED) && !phase_q;
        tdata_d  = tdata_q;
        if (tvalid_d) tdata_d = swap_iq ? {q_word, i_word} : {i_word, q_word};
    end

    // Data checker on each emitted word; clear beats increment.
    always_comb begin
        mode_chg = (check_mode != mode_q);
        mode_d   = check_mode;
        word_err = 1'b0;
        ref_d    = ref_q;
        seeded_d = seeded_q;
        if (tvalid_q) begin
            if (check_mode == MODE_RAMP && seeded_q && !mode_chg) begin
                word_err = (tdata_q[31:16] != ref_q[31:16] + 16'd1) ||
                           (tdata_q[15:0]  != ref_q[15:0]  + 16'd1);
            end else if (check_mode == MODE_FIXED) begin
                word_err = (tdata_q != fixed_pattern);
            end
            ref_d    = tdata_q;
            seeded_d = 1'b1;
        end else if (mode_chg || state_q != ST_LOCKED) begin
            seeded_d = 1'b0;
        end
        check_err_d = check_err_q;
        if (check_err_clr)  check_err_d = 16'd0;
        else if (word_err)  check_err_d = sat_inc16(check_err_q);
    end

    // Control and output registers.
    always_ff @(posedge serdes_clk_div) begin
        if (rst) begin
            state_q      <= ST_SEARCH;
            phase_q      <= 1'b0;
            offset_q     <= 3'd0;
            match_cnt_q  <= 8'd0;
            bad_run_q    <= 8'd0;
            zero_ok_q    <= 1'b0;
            strobe_err_q <= 16'd0;
            tdata_q      <= 32'd0;
            tvalid_q     <= 1'b0;
            check_err_q  <= 16'd0;
            ref_q        <= 32'd0;
            seeded_q     <= 1'b0;
            mode_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            offset_q     <= offset_d;
            match_cnt_q  <= match_cnt_d;
            bad_run_q    <= bad_run_d;
            zero_ok_q    <= zero_ok_d;
            strobe_err_q <= strobe_err_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            check_err_q  <= check_err_d;
            ref_q        <= ref_d;
            seeded_q     <= seeded_d;
            mode_q       <= mode_d;
        end
    end

    assign m_axis_tdata   = tdata_q;
    assign m_axis_tvalid  = tvalid_q;
    assign locked         = (state_q == ST_LOCKED);
    assign strobe_offset  = offset_q;
    assign strobe_err_cnt = strobe_err_q;
    assign check_err_cnt  = check_err_q;

endmodule

// File: tb/tb_adrv9001_rx_ssi_unpack.sv
// Directed bench for adrv9001_rx_ssi_unpack: a bit-serial model of the SSI
// lanes is packed into 8-bit words, MSB earliest, and fed to the deframer.
`timescale 1ns/1ps
module tb_adrv9001_rx_ssi_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  s_din = 8'd0, i_din = 8'd0, q_din = 8'd0;
    logic        swap_iq = 1'b0;
    logic [1:0]  check_mode = 2'd0;
    logic [31:0] fixed_pattern = 32'd0;
    logic        check_err_clr = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        locked;
    logic [2:0]  strobe_offset;
    logic [15:0] strobe_err_cnt;
    logic [15:0] check_err_cnt;

    adrv9001_rx_ssi_unpack #(.LOCK_COUNT(8), .UNLOCK_COUNT(4)) dut (
        .serdes_clk_div(clk), .rst(rst), .enable(enable),
        .s_din(s_din), .i_din(i_din), .q_din(q_din),
        .swap_iq(swap_iq), .check_mode(check_mode), .fixed_pattern(fixed_pattern),
        .check_err_clr(check_err_clr),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .locked(locked),
        .strobe_offset(strobe_offset), .strobe_err_cnt(strobe_err_cnt),
        .check_err_cnt(check_err_cnt)
    );

    always #5 clk = ~clk;

    bit sq[$];
    bit iq[$];
    bit qq[$];

    int n_vec = 0;
    int n_err = 0;

    // Observation state gathered each cycle.
    int          cyc;
    int          first_vld;
    int          lock_cyc;
    int          vld_cnt;
    int          n_ne;
    bit          two_in_row;
    bit          prev_vld;
    logic [31:0] last_data;
    logic [31:0] watch_word;

    task automatic clear_stats();
        first_vld  = -1;
        lock_cyc   = -1;
        vld_cnt    = 0;
        n_ne       = 0;
        two_in_row = 1'b0;
        last_data  = 32'd0;
    endtask

    task automatic push_sample(input logic [15:0] iv, input logic [15:0] qv, input logic [15:0] sv);
        for (int k = 15; k >= 0; k--) begin
            sq.push_back(sv[k]);
            iq.push_back(iv[k]);
            qq.push_back(qv[k]);
        end
    endtask

    task automatic push_pad(input int n);
        for (int k = 0; k < n; k++) begin
            sq.push_back(1'b0);
            iq.push_back(1'b0);
            qq.push_back(1'b0);
        end
    endtask

    // Drive one word per lane, clock once, then observe 1 ns after the edge.
    task automatic step();
        logic [7:0] sw, iw, qw;
        sw = 8'd0; iw = 8'd0; qw = 8'd0;
        for (int k = 7; k >= 0; k--) begin
            if (sq.size() > 0) sw[k] = sq.pop_front();
            if (iq.size() > 0) iw[k] = iq.pop_front();
            if (qq.size() > 0) qw[k] = qq.pop_front();
        end
        s_din = sw; i_din = iw; q_din = qw;
        @(posedge clk);
        #1;
        cyc++;
        if (m_axis_tvalid) begin
            vld_cnt++;
            last_data = m_axis_tdata;
            if (first_vld < 0) first_vld = cyc;
            if (m_axis_tdata !== watch_word) n_ne++;
            if (prev_vld) two_in_row = 1'b1;
        end
        if (locked && lock_cyc < 0) lock_cyc = cyc;
        prev_vld = m_axis_tvalid;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Reset with an empty stream, then restart the cycle count at 0.
    task automatic begin_test();
        sq.delete(); iq.delete(); qq.delete();
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        enable = 1'b1;
        cyc = 0;
        prev_vld = 1'b0;
        clear_stats();
    endtask

    task automatic test_reset();
        sq.delete(); iq.delete(); qq.delete();
        enable = 1'b1;
        for (int m = 0; m < 4; m++) push_sample(16'h1234, 16'hABCD, 16'h8000);
        rst = 1'b1;
        run(5);
        n_vec++; if (m_axis_tdata !== 32'd0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_vec++; if (strobe_offset !== 3'd0) begin n_err++; $display("FAIL reset_offset: got %0d want 0", strobe_offset); end
        n_vec++; if (strobe_err_cnt !== 16'd0) begin n_err++; $display("FAIL reset_strobe_err: got %0d want 0", strobe_err_cnt); end
        n_vec++; if (check_err_cnt !== 16'd0) begin n_err++; $display("FAIL reset_check_err: got %0d want 0", check_err_cnt); end
    endtask

    task automatic test_aligned();
        swap_iq = 1'b0; check_mode = 2'd0;
        begin_test();
        for (int m = 0; m < 30; m++) push_sample(16'h1234, 16'hABCD, 16'h8000);
        watch_word = 32'h1234ABCD;
        run(40);
        n_vec++; if (lock_cyc != 18) begin n_err++; $display("FAIL aligned_lock_cycle: got %0d want 18", lock_cyc); end
        n_vec++; if (first_vld != 20) begin n_err++; $display("FAIL aligned_first_valid: got %0d want 20", first_vld); end
        n_vec++; if (vld_cnt != 11) begin n_err++; $display("FAIL aligned_valid_count: got %0d want 11", vld_cnt); end
        n_vec++; if (two_in_row !== 1'b0) begin n_err++; $display("FAIL aligned_duty: got back-to-back valid, want none"); end
        n_vec++; if (n_ne != 0) begin n_err++; $display("FAIL aligned_data: %0d words differ from %h, last %h", n_ne, watch_word, last_data); end
        n_vec++; if (strobe_offset !== 3'd0) begin n_err++; $display("FAIL aligned_offset: got %0d want 0", strobe_offset); end
    endtask

    task automatic test_offsets();
        swap_iq = 1'b0; check_mode = 2'd0;
        for (int b = 1; b < 8; b++) begin
            begin_test();
            push_pad(b);
            for (int m = 0; m < 25; m++) push_sample(16'h1234, 16'hABCD, 16'h8000);
            watch_word = 32'h1234ABCD;
            run(30);
            n_vec++; if (strobe_offset !== 3'(b)) begin n_err++; $display("FAIL offset_%0d_value: got %0d want %0d", b, strobe_offset, b); end
            n_vec++; if (first_vld != 20) begin n_err++; $display("FAIL offset_%0d_first_valid: got %0d want 20", b, first_vld); end
            n_vec++; if (vld_cnt != 6) begin n_err++; $display("FAIL offset_%0d_valid_count: got %0d want 6", b, vld_cnt); end
            n_vec++; if (n_ne != 0) begin n_err++; $display("FAIL offset_%0d_data: %0d words differ, last %h want %h", b, n_ne, last_data, watch_word); end
        end
    endtask

    task automatic test_swap();
        swap_iq = 1'b1; check_mode = 2'd0;
        begin_test();
        push_pad(3);
        for (int m = 0; m < 25; m++) push_sample(16'h1234, 16'hABCD, 16'h8000);
        watch_word = 32'hABCD1234;
        run(30);
        n_vec++; if (vld_cnt != 6) begin n_err++; $display("FAIL swap_valid_count: got %0d want 6", vld_cnt); end
        n_vec++; if (n_ne != 0) begin n_err++; $display("FAIL swap_data: %0d words differ, last %h want %h", n_ne, last_data, watch_word); end
        n_vec++; if (two_in_row !== 1'b0) begin n_err++; $display("FAIL swap_duty: got back-to-back valid, want none"); end
        swap_iq = 1'b0;
    endtask

    task automatic test_ramp();
        logic [15:0] v;
        swap_iq = 1'b0; check_mode = 2'd1;
        begin_test();
        for (int m = 0; m < 40; m++) begin
            v = 16'(16'hFFF6 + m);
            if (m == 20) push_sample(v ^ 16'h0100, v, 16'h8000);
            else         push_sample(v, v, 16'h8000);
        end
        watch_word = 32'hFFFEFFFE;
        run(21);
        n_vec++; if (last_data !== 32'hFFFEFFFE) begin n_err++; $display("FAIL ramp_first_word: got %h want fffefffe", last_data); end
        run(19);
        n_vec++; if (check_err_cnt !== 16'd0) begin n_err++; $display("FAIL ramp_clean_wrap: got %0d want 0", check_err_cnt); end
        run(20);
        n_vec++; if (check_err_cnt !== 16'd2) begin n_err++; $display("FAIL ramp_corrupt: got %0d want 2", check_err_cnt); end
        check_mode = 2'd0;
    endtask

    task automatic test_fixed();
        swap_iq = 1'b0; check_mode = 2'd2; fixed_pattern = 32'h7FFF7FFF;
        begin_test();
        for (int m = 0; m < 30; m++) begin
            if (m == 12 || m == 20) push_sample(16'h7FFF, 16'h7FFE, 16'h8000);
            else                    push_sample(16'h7FFF, 16'h7FFF, 16'h8000);
        end
        run(44);
        n_vec++; if (check_err_cnt !== 16'd1) begin n_err++; $display("FAIL fixed_one_error: got %0d want 1", check_err_cnt); end
        n_vec++; if (m_axis_tdata !== 32'h7FFF7FFE) begin n_err++; $display("FAIL fixed_bad_word: got %h want 7fff7ffe", m_axis_tdata); end
        check_err_clr = 1'b1;
        run(1);
        check_err_clr = 1'b0;
        n_vec++; if (check_err_cnt !== 16'd0) begin n_err++; $display("FAIL fixed_clear_wins: got %0d want 0", check_err_cnt); end
        run(8);
        n_vec++; if (check_err_cnt !== 16'd0) begin n_err++; $display("FAIL fixed_after_clear: got %0d want 0", check_err_cnt); end
        check_mode = 2'd0;
    endtask

    task automatic test_glitch();
        swap_iq = 1'b0; check_mode = 2'd0;
        begin_test();
        for (int m = 0; m < 45; m++) begin
            if ((m >= 12 && m <= 14) || (m >= 20 && m <= 23)) push_sample(16'h1234, 16'hABCD, 16'h0000);
            else                                             push_sample(16'h1234, 16'hABCD, 16'h8000);
        end
        run(36);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL glitch3_locked: got %b want 1", locked); end
        n_vec++; if (strobe_err_cnt !== 16'd3) begin n_err++; $display("FAIL glitch3_count: got %0d want 3", strobe_err_cnt); end
        run(11);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL glitch4_still_locked: got %b want 1", locked); end
        n_vec++; if (strobe_err_cnt !== 16'd6) begin n_err++; $display("FAIL glitch4_count6: got %0d want 6", strobe_err_cnt); end
        run(1);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL glitch4_unlock: got %b want 0", locked); end
        n_vec++; if (strobe_err_cnt !== 16'd7) begin n_err++; $display("FAIL glitch4_count7: got %0d want 7", strobe_err_cnt); end
        vld_cnt = 0;
        run(12);
        n_vec++; if (vld_cnt != 0) begin n_err++; $display("FAIL glitch_valid_stops: got %0d valid words want 0", vld_cnt); end
        run(10);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL glitch_relock: got %b want 1", locked); end
        n_vec++; if (strobe_err_cnt !== 16'd0) begin n_err++; $display("FAIL glitch_relock_clear: got %0d want 0", strobe_err_cnt); end
    endtask

    task automatic test_enable_reset();
        swap_iq = 1'b0; check_mode = 2'd2; fixed_pattern = 32'd0;
        begin_test();
        push_pad(5);
        for (int m = 0; m < 40; m++) begin
            if (m == 30) push_sample(16'h1234, 16'hABCD, 16'h0000);
            else         push_sample(16'h1234, 16'hABCD, 16'h8000);
        end
        run(31);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL en_locked: got %b want 1", locked); end
        n_vec++; if (strobe_offset !== 3'd5) begin n_err++; $display("FAIL en_offset: got %0d want 5", strobe_offset); end
        n_vec++; if (check_err_cnt !== 16'd6) begin n_err++; $display("FAIL en_fixed_count: got %0d want 6", check_err_cnt); end
        enable = 1'b0;
        run(1);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL en_fall_tvalid: got %b want 0", m_axis_tvalid); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL en_fall_locked: got %b want 0", locked); end
        vld_cnt = 0;
        run(8);
        n_vec++; if (vld_cnt != 0) begin n_err++; $display("FAIL en_low_valid: got %0d valid words want 0", vld_cnt); end
        enable = 1'b1;
        lock_cyc = -1; first_vld = -1;
        run(17);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL en_relock_early: got %b want 0", locked); end
        run(7);
        n_vec++; if (lock_cyc != 58) begin n_err++; $display("FAIL en_relock_cycle: got %0d want 58", lock_cyc); end
        n_vec++; if (first_vld != 60) begin n_err++; $display("FAIL en_relock_first_valid: got %0d want 60", first_vld); end
        n_vec++; if (strobe_err_cnt !== 16'd1) begin n_err++; $display("FAIL en_strobe_err: got %0d want 1", strobe_err_cnt); end
        n_vec++; if (m_axis_tdata !== 32'h1234ABCD) begin n_err++; $display("FAIL en_relock_data: got %h want 1234abcd", m_axis_tdata); end
        rst = 1'b1;
        run(1);
        n_vec++; if (m_axis_tdata !== 32'd0) begin n_err++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %b want 0", locked); end
        n_vec++; if (strobe_offset !== 3'd0) begin n_err++; $display("FAIL rst_offset: got %0d want 0", strobe_offset); end
        n_vec++; if (strobe_err_cnt !== 16'd0) begin n_err++; $display("FAIL rst_strobe_err: got %0d want 0", strobe_err_cnt); end
        n_vec++; if (check_err_cnt !== 16'd0) begin n_err++; $display("FAIL rst_check_err: got %0d want 0", check_err_cnt); end
        rst = 1'b0;
        check_mode = 2'd0;
    endtask

    initial begin
        cyc = 0;
        prev_vld = 1'b0;
        watch_word = 32'd0;
        clear_stats();
        test_reset();
        test_aligned();
        test_offsets();
        test_swap();
        test_ramp();
        test_fixed();
        test_glitch();
        test_enable_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
